// File: rtl/dsp_pkg.sv
// Shared widths and controller state encoding for the DSP streaming slice.
package dsp_pkg;

  localparam int A_W = 18;
  localparam int C_W = 48;
  localparam int P_W = 48;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/dsp_result_fifo.sv
// First-word fall-through result FIFO; extra pointer bit separates full from empty.
module dsp_result_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 49
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_pop;

  assign count    = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // When full, a same-cycle pop vacates exactly the slot being written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !do_pop));

endmodule

// File: rtl/dsp_stream_ctrl.sv
// Operand issuer and result collector around a fixed-latency DSP slice with credit-based issue.
module dsp_stream_ctrl
  import dsp_pkg::*;
#(
  parameter int DSP_LATENCY = 4,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [A_W-1:0] in_a,
  input  logic [A_W-1:0] in_b,
  input  logic [C_W-1:0] in_c,
  input  logic [A_W-1:0] in_d,
  input  logic           in_last,
  output logic [A_W-1:0] dsp_a,
  output logic [A_W-1:0] dsp_b,
  output logic [C_W-1:0] dsp_c,
  output logic [A_W-1:0] dsp_d,
  input  logic [P_W-1:0] dsp_p,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [P_W-1:0] out_p,
  output logic           out_last,
  output logic           busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  ctrl_state_t            state;
  logic [CW-1:0]          inflight;
  logic [CW-1:0]          fifo_count;
  logic [CW:0]            credit_used;
  logic [DSP_LATENCY-1:0] vld_sr;
  logic [DSP_LATENCY-1:0] last_sr;
  logic                   accept;
  logic                   tail_push;
  logic                   out_fire;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic [P_W:0]           fifo_rd;

  // Every issued beat owns a FIFO slot from issue until pop, so a push can never overflow.
  assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};
  assign in_ready    = rst_n && (state != DRAIN) && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign accept      = in_valid && in_ready;
  assign tail_push   = vld_sr[DSP_LATENCY-1];
  assign out_valid   = !fifo_empty;
  assign out_p       = fifo_rd[P_W-1:0];
  assign out_last    = fifo_rd[P_W];
  assign out_fire    = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsp_a <= '0;
      dsp_b <= '0;
      dsp_c <= '0;
      dsp_d <= '0;
    end else if (accept) begin
      dsp_a <= in_a;
      dsp_b <= in_b;
      dsp_c <= in_c;
      dsp_d <= in_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr  <= '0;
      last_sr <= '0;
    end else begin
      vld_sr  <= (vld_sr << 1)  | DSP_LATENCY'(accept);
      last_sr <= (last_sr << 1) | DSP_LATENCY'(accept && in_last);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      case ({accept, tail_push})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  // A job whose first beat is also its last goes straight to DRAIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= in_last ? DRAIN : RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (accept && in_last) state <= DRAIN;
        end
        DRAIN: begin
          if (out_fire && out_last) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  dsp_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (P_W + 1)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tail_push),
    .push_data ({last_sr[DSP_LATENCY-1], dsp_p}),
    .pop       (out_ready),
    .pop_data  (fifo_rd),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  a_push_has_room : assert property (@(posedge clk) disable iff (!rst_n)
    !(tail_push && fifo_full && !out_ready));

endmodule

// File: tb/tb_dsp_stream_ctrl.sv
// Scoreboard bench for dsp_stream_ctrl with a latency-4 DSP model computing P = (D + A) * B + C.
module tb_dsp_stream_ctrl;

   typedef struct packed {
      logic [47:0] p;
      logic        last;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [17:0] in_a;
   logic [17:0] in_b;
   logic [47:0] in_c;
   logic [17:0] in_d;
   logic        in_last;
   logic [17:0] dsp_a;
   logic [17:0] dsp_b;
   logic [47:0] dsp_c;
   logic [17:0] dsp_d;
   logic [47:0] dsp_p;
   logic        out_valid;
   logic        out_ready;
   logic [47:0] out_p;
   logic        out_last;
   logic        busy;

   int   total;
   int   bad;
   int   n_pop;
   int   seq;
   exp_t sb[$];

   logic        samp_in_ready;
   logic        samp_out_valid;
   logic        samp_busy;
   logic [47:0] samp_out_p;
   logic        samp_out_last;

   logic [47:0] s1, s2, s3;

   dsp_stream_ctrl #(
      .DSP_LATENCY (4),
      .FIFO_DEPTH  (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_c      (in_c),
      .in_d      (in_d),
      .in_last   (in_last),
      .dsp_a     (dsp_a),
      .dsp_b     (dsp_b),
      .dsp_c     (dsp_c),
      .dsp_d     (dsp_d),
      .dsp_p     (dsp_p),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_p     (out_p),
      .out_last  (out_last),
      .busy      (busy)
   );

   function automatic logic [47:0] dspModel(logic [17:0] a, logic [17:0] b, logic [17:0] d, logic [47:0] c);
      return (48'(d) + 48'(a)) * 48'(b) + c;
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // DSP slice: operands registered in the DUT, three more stages here, sampled on the fourth edge
   always @(posedge clk) begin
      s1 <= dspModel(dsp_a, dsp_b, dsp_d, dsp_c);
      s2 <= s1;
      s3 <= s2;
   end
   assign dsp_p = s3;

   task automatic checkOutput(input string name, input logic [47:0] actual, input logic [47:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input bit valid, input bit last, input bit ordy,
                                input logic [17:0] a, input logic [17:0] b,
                                input logic [17:0] d, input logic [47:0] c,
                                output bit accepted);
      exp_t e;
      @(negedge clk);
      in_valid  = valid;
      in_last   = last;
      in_a      = a;
      in_b      = b;
      in_c      = c;
      in_d      = d;
      out_ready = ordy;
      #1;
      samp_in_ready  = in_ready;
      samp_out_valid = out_valid;
      samp_busy      = busy;
      samp_out_p     = out_p;
      samp_out_last  = out_last;
      accepted = valid && in_ready;
      if (accepted) begin
         e.p    = dspModel(a, b, d, c);
         e.last = last;
         sb.push_back(e);
      end
      @(posedge clk);
   endtask

   task automatic idleCycle(input bit ordy);
      bit acc;
      applyStimulus(1'b0, 1'b0, ordy, '0, '0, '0, '0, acc);
   endtask

   task automatic seqBeat(input bit last, input bit ordy, output bit accepted);
      applyStimulus(1'b1, last, ordy, 18'(seq * 7 + 3), 18'(seq + 1), 18'(seq), 48'(seq * 11), accepted);
      if (accepted) seq++;
   endtask

   // Monitor: pops the scoreboard on each output handshake and checks stalled outputs hold
   logic        prev_stall;
   logic [47:0] held_p;
   logic        held_last;
   initial prev_stall = 1'b0;
   always begin
      exp_t e;
      @(negedge clk);
      #2;
      if (rst_n) begin
         if (prev_stall && out_valid) begin
            checkOutput("stall_hold_p", out_p, held_p);
            checkOutput("stall_hold_last", 48'(out_last), 48'(held_last));
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checkOutput("spurious_out_valid", 48'(out_valid), 48'd0);
            end else begin
               e = sb.pop_front();
               checkOutput("out_p", out_p, e.p);
               checkOutput("out_last", 48'(out_last), 48'(e.last));
               n_pop++;
            end
         end
         prev_stall = out_valid && !out_ready;
         held_p     = out_p;
         held_last  = out_last;
      end else begin
         prev_stall = 1'b0;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit acc;
      int n_acc;
      int p0;
      total = 0;
      bad   = 0;
      n_pop = 0;
      seq   = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_c      = '0;
      in_d      = '0;
      out_ready = 1'b0;

      // Reset values
      repeat (2) @(negedge clk);
      #1;
      checkOutput("rst_in_ready", 48'(in_ready), 48'd0);
      checkOutput("rst_out_valid", 48'(out_valid), 48'd0);
      checkOutput("rst_busy", 48'(busy), 48'd0);
      checkOutput("rst_dsp_c", dsp_c, 48'd0);
      checkOutput("rst_out_p", out_p, 48'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idleCycle(1'b1);
      checkOutput("post_rst_in_ready", 48'(samp_in_ready), 48'd1);

      // Single beat: (3 + 2) * 4 + 5 = 25, out_valid exactly 4 cycles after accept
      $display("[TB] single beat");
      applyStimulus(1'b1, 1'b1, 1'b1, 18'd2, 18'd4, 18'd3, 48'd5, acc);
      checkOutput("single_accept", 48'(acc), 48'd1);
      checkOutput("single_dsp_a", 48'(dsp_a), 48'd0);
      for (int k = 1; k <= 6; k++) begin
         idleCycle(1'b1);
         if (k == 1) begin
            checkOutput("single_dsp_a_loaded", 48'(dsp_a), 48'd2);
            checkOutput("single_dsp_c_loaded", dsp_c, 48'd5);
            checkOutput("single_busy", 48'(samp_busy), 48'd1);
         end
         if (k == 4) checkOutput("single_early_valid", 48'(samp_out_valid), 48'd0);
         if (k == 5) begin
            checkOutput("single_valid_lat4", 48'(samp_out_valid), 48'd1);
            checkOutput("single_out_p", samp_out_p, 48'd25);
            checkOutput("single_out_last", 48'(samp_out_last), 48'd1);
            checkOutput("single_drain_in_ready", 48'(samp_in_ready), 48'd0);
         end
         if (k == 6) begin
            checkOutput("single_busy_clear", 48'(samp_busy), 48'd0);
            checkOutput("single_in_ready_back", 48'(samp_in_ready), 48'd1);
         end
      end

      // 20 back-to-back directed beats, last one at all-ones operands
      $display("[TB] back-to-back stream");
      p0 = n_pop;
      for (int i = 0; i < 20; i++) begin
         if (i == 19)
            applyStimulus(1'b1, 1'b1, 1'b1, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 48'hFFFF_FFFF_FFFF, acc);
         else
            applyStimulus(1'b1, 1'b0, 1'b1, 18'(i * 37 + 1), 18'(i + 2), 18'(i * 5), 48'(i * 1000), acc);
         checkOutput("stream_in_ready", 48'(samp_in_ready), 48'd1);
         if (i >= 5) checkOutput("stream_out_valid", 48'(samp_out_valid), 48'd1);
      end
      repeat (7) idleCycle(1'b1);
      checkOutput("stream_pop_count", 48'(n_pop - p0), 48'd20);

      // Output stalled with input held: credits allow exactly FIFO_DEPTH beats
      $display("[TB] backpressure fill");
      n_acc = 0;
      for (int i = 0; i < 14; i++) begin
         seqBeat(1'b0, 1'b0, acc);
         if (acc) n_acc++;
      end
      checkOutput("bp_accepted", 48'(n_acc), 48'd8);
      checkOutput("bp_in_ready_low", 48'(samp_in_ready), 48'd0);
      repeat (12) idleCycle(1'b1);
      checkOutput("bp_drained", 48'(sb.size()), 48'd0);

      // Full FIFO with toggling out_ready exercises simultaneous push and pop
      $display("[TB] full fifo toggling");
      for (int i = 0; i < 14; i++) seqBeat(1'b0, 1'b0, acc);
      checkOutput("full_in_ready_low", 48'(samp_in_ready), 48'd0);
      for (int i = 0; i < 30; i++) seqBeat(1'b0, 1'(i % 2), acc);
      repeat (16) idleCycle(1'b1);
      checkOutput("toggle_drained", 48'(sb.size()), 48'd0);

      // in_last closes the job: no acceptance until the out_last handshake
      $display("[TB] last beat blocks input");
      seqBeat(1'b1, 1'b0, acc);
      checkOutput("last_accept", 48'(acc), 48'd1);
      for (int i = 0; i < 6; i++) begin
         seqBeat(1'b0, 1'b0, acc);
         checkOutput("last_blocked", 48'(acc), 48'd0);
      end
      idleCycle(1'b1);
      seqBeat(1'b0, 1'b1, acc);
      checkOutput("next_job_accept", 48'(acc), 48'd1);

      // Reset with beats in flight discards everything
      $display("[TB] reset mid-flight");
      for (int i = 0; i < 2; i++) seqBeat(1'b0, 1'b1, acc);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      sb.delete();
      #1;
      checkOutput("midrst_in_ready", 48'(in_ready), 48'd0);
      checkOutput("midrst_out_valid", 48'(out_valid), 48'd0);
      checkOutput("midrst_busy", 48'(busy), 48'd0);
      checkOutput("midrst_dsp_a", 48'(dsp_a), 48'd0);
      checkOutput("midrst_out_p", out_p, 48'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         idleCycle(1'b1);
         checkOutput("postrst_no_valid", 48'(samp_out_valid), 48'd0);
      end
      checkOutput("postrst_in_ready", 48'(samp_in_ready), 48'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
